// File: rtl/shared_mem_arbiter_pkg.sv
// Shared definitions for the shared-memory arbiter: bus widths, the
// local/shared address split and the round-robin search helper.
package shared_mem_arbiter_pkg;

  localparam int SHARED_ADDR_WIDTH = 16;
  localparam int SHARED_DATA_WIDTH = 16;

  localparam int MAX_CORES = 16;
  localparam int RR_IDX_W  = 4;

  // Top address bits select the region; 00 stays inside the core.
  localparam int         REGION_BITS  = 2;
  localparam logic [1:0] LOCAL_REGION = 2'b00;

  function automatic logic is_local(input logic [SHARED_ADDR_WIDTH-1:0] addr);
    return addr[SHARED_ADDR_WIDTH-1 -: REGION_BITS] == LOCAL_REGION;
  endfunction

  // One-hot winner: first set bit of request_mask after last_grant, wrapping.
  function automatic logic [MAX_CORES-1:0] rr_next(
    input logic [MAX_CORES-1:0] request_mask,
    input logic [RR_IDX_W-1:0]  last_grant,
    input int                   num_cores
  );
    logic [MAX_CORES-1:0] grant;
    logic                 found;
    int                   idx;
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_CORES; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= num_cores) idx = idx - num_cores;
      if (k <= num_cores && !found && request_mask[idx[RR_IDX_W-1:0]]) begin
        grant[idx[RR_IDX_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/shared_mem_arbiter_rr_select.sv
// Combinational round-robin picker: one-hot winner, its index, and whether
// anyone was eligible at all.
module shared_mem_arbiter_rr_select
  import shared_mem_arbiter_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] eligible,
  input  logic [IDX_W-1:0]     last_grant,
  output logic [NUM_CORES-1:0] grant,
  output logic [IDX_W-1:0]     index,
  output logic                 any_valid
);

  logic [MAX_CORES-1:0] pick;

  assign pick      = rr_next(MAX_CORES'(eligible), RR_IDX_W'(last_grant), NUM_CORES);
  assign grant     = pick[NUM_CORES-1:0];
  assign any_valid = |eligible;

  always_comb begin
    index = '0;
    for (int i = 0; i < MAX_CORES; i++) begin
      if (pick[i]) index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter putting NUM_CORES core request buses onto one
// synchronous SRAM port; grant and memory-port signals are all registered.
module shared_mem_arbiter
  import shared_mem_arbiter_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int ADDR_WIDTH = SHARED_ADDR_WIDTH,
  parameter int DATA_WIDTH = SHARED_DATA_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_CORES-1:0]            core_request,
  input  logic [NUM_CORES-1:0]            core_wren,
  input  logic [NUM_CORES-1:0]            core_rden,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] core_addr,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] core_write_val,
  output logic [NUM_CORES-1:0]            core_ready,
  output logic [DATA_WIDTH-1:0]           core_read_val,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic                            mem_wren,
  output logic                            mem_rden,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic [DATA_WIDTH-1:0]           mem_q
);

  localparam int IDX_W = $clog2(NUM_CORES);

  logic [NUM_CORES-1:0]  grant_r;
  logic [IDX_W-1:0]      last_grant;
  logic [NUM_CORES-1:0]  eligible;
  logic [NUM_CORES-1:0]  win_grant;
  logic [IDX_W-1:0]      win_idx;
  logic                  win_valid;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // The core served this cycle still holds its request; keep it out.
  assign eligible = core_request & ~grant_r;

  shared_mem_arbiter_rr_select #(
    .NUM_CORES (NUM_CORES),
    .IDX_W     (IDX_W)
  ) u_rr_select (
    .eligible   (eligible),
    .last_grant (last_grant),
    .grant      (win_grant),
    .index      (win_idx),
    .any_valid  (win_valid)
  );

  always_comb begin
    sel_addr  = core_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
    sel_wdata = core_write_val[win_idx*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_r    <= '0;
      last_grant <= IDX_W'(NUM_CORES - 1);
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wren   <= 1'b0;
      mem_rden   <= 1'b0;
    end else if (win_valid) begin
      grant_r    <= win_grant;
      last_grant <= win_idx;
      mem_addr   <= sel_addr;
      mem_wdata  <= sel_wdata;
      mem_wren   <= core_wren[win_idx];
      mem_rden   <= core_rden[win_idx] & ~core_wren[win_idx];
    end else begin
      grant_r    <= '0;
      mem_wren   <= 1'b0;
      mem_rden   <= 1'b0;
    end
  end

  assign core_ready    = grant_r;
  assign core_read_val = mem_q;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed plus randomized bench for shared_mem_arbiter with a behavioural
// SRAM and a transaction-level reference model.
module tb_shared_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    core_request, core_wren, core_rden;
  logic [N*AW-1:0] core_addr;
  logic [N*DW-1:0] core_write_val;
  logic [N-1:0]    core_ready;
  logic [DW-1:0]   core_read_val;
  logic [AW-1:0]   mem_addr;
  logic            mem_wren, mem_rden;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_q = '0;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sram    [0:65535];
  logic [DW-1:0] ref_mem [0:65535];

  // reference model state
  int          m_last, m_prev;
  bit          pend_wr, pend_rd;
  logic [15:0] pend_wa, pend_wd, pend_rv;
  logic [15:0] e_addr, e_wdata;

  shared_mem_arbiter #(.NUM_CORES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .core_request   (core_request),
    .core_wren      (core_wren),
    .core_rden      (core_rden),
    .core_addr      (core_addr),
    .core_write_val (core_write_val),
    .core_ready     (core_ready),
    .core_read_val  (core_read_val),
    .mem_addr       (mem_addr),
    .mem_wren       (mem_wren),
    .mem_rden       (mem_rden),
    .mem_wdata      (mem_wdata),
    .mem_q          (mem_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wren) sram[mem_addr] <= mem_wdata;
    if (mem_rden) mem_q <= sram[mem_addr];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_core(input int i, input bit r, input bit w, input bit rd,
                          input logic [15:0] a, input logic [15:0] d);
    core_request[i]         = r;
    core_wren[i]            = w;
    core_rden[i]            = rd;
    core_addr[i*AW +: AW]      = a;
    core_write_val[i*DW +: DW] = d;
  endtask

  task automatic clear_all();
    core_request = '0; core_wren = '0; core_rden = '0;
    core_addr = '0; core_write_val = '0;
  endtask

  task automatic model_reset();
    m_last = N - 1; m_prev = -1;
    pend_wr = 0; pend_rd = 0;
    e_addr = '0; e_wdata = '0;
  endtask

  // One clock: predict from current inputs, step, compare every output.
  task automatic cycle();
    int          w, idx;
    bit          chk_rd, e_wren, e_rden;
    logic [15:0] chk_rv;
    logic [N-1:0] e_ready;
    if (pend_wr) ref_mem[pend_wa] = pend_wd;
    pend_wr = 0;
    chk_rd = pend_rd; chk_rv = pend_rv; pend_rd = 0;
    w = -1;
    for (int k = 1; k <= N; k++) begin
      idx = (m_last + k) % N;
      if (w < 0 && core_request[idx] && idx != m_prev) w = idx;
    end
    e_ready = '0; e_wren = 0; e_rden = 0;
    if (w >= 0) begin
      e_ready[w] = 1'b1;
      e_addr  = core_addr[w*AW +: AW];
      e_wdata = core_write_val[w*DW +: DW];
      e_wren  = core_wren[w];
      e_rden  = core_rden[w] && !core_wren[w];
      m_last  = w;
      if (e_wren) begin pend_wr = 1; pend_wa = e_addr; pend_wd = e_wdata; end
      if (e_rden) begin pend_rd = 1; pend_rv = ref_mem[e_addr]; end
    end
    m_prev = w;
    @(posedge clk); #1;
    chk("ready", 32'(core_ready), 32'(e_ready));
    chk("mem_wren", 32'(mem_wren), 32'(e_wren));
    chk("mem_rden", 32'(mem_rden), 32'(e_rden));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    if (chk_rd) chk("read_val", 32'(core_read_val), 32'(chk_rv));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_all();
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin sram[a] = '0; ref_mem[a] = '0; end
    sram[16'h4010] = 16'hBEEF; ref_mem[16'h4010] = 16'hBEEF;
    reset_n = 1'b0;
    clear_all();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(core_ready), 32'h0);
    chk("rst_wren", 32'(mem_wren), 32'h0);
    chk("rst_rden", 32'(mem_rden), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_wdata", 32'(mem_wdata), 32'h0);
    reset_n = 1'b1;

    // single read by core 1
    set_core(1, 1, 0, 1, 16'h4010, 16'h0);
    cycle();
    chk("rd_ready", 32'(core_ready), 32'h2);
    chk("rd_rden", 32'(mem_rden), 32'h1);
    chk("rd_addr", 32'(mem_addr), 32'h4010);
    clear_all();
    cycle();
    chk("rd_data", 32'(core_read_val), 32'hBEEF);

    // write by core 2, read back by core 0
    set_core(2, 1, 1, 0, 16'h8000, 16'h1234);
    cycle();
    chk("wr_ready", 32'(core_ready), 32'h4);
    chk("wr_wren", 32'(mem_wren), 32'h1);
    chk("wr_addr", 32'(mem_addr), 32'h8000);
    chk("wr_wdata", 32'(mem_wdata), 32'h1234);
    clear_all();
    cycle();
    chk("wr_pulse", 32'(mem_wren), 32'h0);
    set_core(0, 1, 0, 1, 16'h8000, 16'h0);
    cycle();
    chk("rb_ready", 32'(core_ready), 32'h1);
    clear_all();
    cycle();
    chk("rb_data", 32'(core_read_val), 32'h1234);

    // full contention
    do_reset();
    for (int i = 0; i < N; i++) set_core(i, 1, 0, 1, 16'(16'h4000 + i), 16'h0);
    for (int g = 0; g < 8; g++) begin
      cycle();
      chk("contend_order", 32'(core_ready), 32'(1 << (g % N)));
    end

    // back-to-back single core
    do_reset();
    set_core(3, 1, 0, 1, 16'h4010, 16'h0);
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk("b2b_ready", 32'(core_ready), (c % 2 == 0) ? 32'h8 : 32'h0);
    end

    // wrap and skip
    do_reset();
    set_core(2, 1, 0, 0, 16'h0, 16'h0);
    cycle();
    chk("wrap_seed", 32'(core_ready), 32'h4);
    clear_all();
    set_core(0, 1, 0, 0, 16'h0, 16'h0);
    set_core(1, 1, 0, 0, 16'h0, 16'h0);
    cycle();
    chk("wrap_first", 32'(core_ready), 32'h1);
    cycle();
    chk("wrap_second", 32'(core_ready), 32'h2);
    clear_all();
    cycle();
    chk("idle_ready", 32'(core_ready), 32'h0);
    for (int i = 0; i < N; i++) set_core(i, 1, 0, 0, 16'h0, 16'h0);
    cycle();
    chk("idle_keeps_last", 32'(core_ready), 32'h4);

    // reset in the cycle core 0 is granted a write
    do_reset();
    set_core(0, 1, 1, 0, 16'h0060, 16'hDEAD);
    set_core(1, 1, 0, 0, 16'h0, 16'h0);
    cycle();
    chk("mid_grant", 32'(core_ready), 32'h1);
    chk("mid_wren", 32'(mem_wren), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_ready", 32'(core_ready), 32'h0);
    chk("async_wren", 32'(mem_wren), 32'h0);
    chk("async_rden", 32'(mem_rden), 32'h0);
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    set_core(0, 1, 1, 0, 16'h0050, 16'hCAFE);
    cycle();
    chk("post_rst_first", 32'(core_ready), 32'h1);
    clear_all();
    set_core(2, 1, 0, 1, 16'h0060, 16'h0);
    cycle();
    clear_all();
    set_core(3, 1, 0, 1, 16'h0050, 16'h0);
    cycle();
    chk("abandoned_write", 32'(core_read_val), 32'h0);
    clear_all();
    cycle();
    chk("post_rst_write", 32'(core_read_val), 32'hCAFE);

    // randomized traffic against the model
    do_reset();
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        set_core(i, ($urandom_range(0, 9) < 6), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 1) == 1),
                 16'(($urandom_range(0, 3) << 14) | $urandom_range(0, 15)),
                 16'($urandom));
      end
      cycle();
    end
    clear_all();
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
